// File: rtl/alu_share_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_share_arbiter: round-robin share of one external ALU among NUM_REQ   |
// | requesters, two-stage (issue/result) pipeline with valid/ready on both   |
// | sides. Optional macro ALU_ARB_PERF_CNT_EN adds per-requester stall       |
// | counters.                                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package HighLevelControl;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } aluOperation;
endpackage

module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int CNT_W   = 32,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int OPW     = $bits(HighLevelControl::aluOperation)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           ReqValid,
  output logic [NUM_REQ-1:0]           ReqReady,
  input  logic [NUM_REQ*OPW-1:0]       ReqOperation,
  input  logic [NUM_REQ*`XLEN-1:0]     ReqOperandA,
  input  logic [NUM_REQ*`XLEN-1:0]     ReqOperandB,
  output logic                         RspValid,
  input  logic                         RspReady,
  output logic [IDW-1:0]               RspId,
  output logic [`XLEN-1:0]             RspResult,
  output logic [3:0]                   RspFlags,
  output HighLevelControl::aluOperation AluOperation,
  output logic [`XLEN-1:0]             AluOperandA,
  output logic [`XLEN-1:0]             AluOperandB,
  input  logic [`XLEN-1:0]             AluResult,
  input  logic                         Zero,
  input  logic                         oVerflow,
  input  logic                         Negative,
  input  logic                         Carry,
  output logic [NUM_REQ*CNT_W-1:0]     PerfStall
);

  logic               r_s1_valid;
  logic [IDW-1:0]     r_s1_id;
  logic [OPW-1:0]     r_s1_op;
  logic [`XLEN-1:0]   r_s1_a;
  logic [`XLEN-1:0]   r_s1_b;
  logic [IDW-1:0]     r_last;

  logic               w_s2_free;
  logic               w_s1_free;
  logic               w_any;
  logic               w_accept;
  logic [IDW-1:0]     w_gidx;
  logic [NUM_REQ-1:0] w_grant;

  logic [OPW-1:0]     w_req_op [NUM_REQ];
  logic [`XLEN-1:0]   w_req_a  [NUM_REQ];
  logic [`XLEN-1:0]   w_req_b  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_op[gi] = ReqOperation[gi*OPW +: OPW];
    assign w_req_a[gi]  = ReqOperandA[gi*`XLEN +: `XLEN];
    assign w_req_b[gi]  = ReqOperandB[gi*`XLEN +: `XLEN];
  end

  assign w_s2_free = ~RspValid | RspReady;
  assign w_s1_free = ~r_s1_valid | w_s2_free;
  assign w_accept  = w_any & w_s1_free;

  // Search starts just after the last accepted requester; first valid wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && ReqValid[i] && (i == (int'(r_last) + k) % NUM_REQ)) begin
          w_any  = 1'b1;
          w_gidx = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant[i] = w_any && (w_gidx == IDW'(i));
    end
  end

  assign ReqReady = w_grant & {NUM_REQ{w_s1_free}};

  // Idle drive is a harmless ADD 0+0 so the ALU never hits its X default arm.
  assign AluOperation = r_s1_valid ? HighLevelControl::aluOperation'(r_s1_op)
                                   : HighLevelControl::ADD;
  assign AluOperandA  = r_s1_valid ? r_s1_a : '0;
  assign AluOperandB  = r_s1_valid ? r_s1_b : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_last     <= IDW'(NUM_REQ - 1);
      RspValid   <= 1'b0;
      RspId      <= '0;
      RspResult  <= '0;
      RspFlags   <= '0;
    end else begin
      if (w_s2_free) begin
        RspValid <= r_s1_valid;
        if (r_s1_valid) begin
          RspId     <= r_s1_id;
          RspResult <= AluResult;
          RspFlags  <= {Zero, oVerflow, Negative, Carry};
        end
      end
      if (w_s1_free) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_id <= w_gidx;
          r_s1_op <= w_req_op[w_gidx];
          r_s1_a  <= w_req_a[w_gidx];
          r_s1_b  <= w_req_b[w_gidx];
        end
      end
      if (w_accept) begin
        r_last <= w_gidx;
      end
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (ReqValid[gi] && !ReqReady[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    assign PerfStall[gi*CNT_W +: CNT_W] = r_cnt;
  end
`else
  assign PerfStall = '0;
`endif

endmodule

`default_nettype wire
